// File: rtl/gpr_pkg.sv
// Shared widths and the writeback entry type for the GPR writeback path.
package gpr_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer for long-latency results waiting on the write port.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/gpr_wb.sv
// GPR write-port arbiter: ALU results win, long-latency results queue behind them;
// a busy scoreboard tracks registers still awaiting a long-latency write.
module gpr_wb
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DATA_W,
  parameter int RW    = REG_W
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          alu_vld,
  input  logic [RW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_vld,
  output logic          ld_rdy,
  input  logic [RW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  input  logic          iss_vld,
  input  logic          iss_long,
  input  logic [RW-1:0] iss_rd,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  output logic          haz,
  output logic          GPRWr,
  output logic [RW-1:0] rw,
  output logic [DW-1:0] busW
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          head, ld_entry;
  logic            full, empty, xfer, bypass, push, pop;
  logic [CW-1:0]   count;
  logic [2**RW-1:0] busy_q, busy_d;
  logic            wr_q, wr_d;
  logic [RW-1:0]   rw_q, rw_d;
  logic [DW-1:0]   busW_q, busW_d;

  assign ld_entry = '{rd: ld_rd, data: ld_data};
  assign ld_rdy   = !full && !clr;
  assign xfer     = ld_vld && ld_rdy;
  // Nothing queued and the port is free: the offered result skips the FIFO.
  assign bypass   = xfer && (count == '0) && !alu_vld;
  assign push     = xfer && !bypass;
  assign pop      = !alu_vld && !empty && !clr;

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk         (clk),
    .clr         (clr),
    .push_i      (push),
    .push_data_i (ld_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_comb begin
    wr_d   = 1'b0;
    rw_d   = rw_q;
    busW_d = busW_q;
    busy_d = busy_q;
    if (alu_vld) begin
      wr_d   = (alu_rd != RW'(REG_ZERO));
      rw_d   = alu_rd;
      busW_d = alu_data;
    end else if (pop) begin
      wr_d   = (head.rd != RW'(REG_ZERO));
      rw_d   = head.rd;
      busW_d = head.data;
      busy_d[head.rd] = 1'b0;
    end else if (bypass) begin
      wr_d   = (ld_rd != RW'(REG_ZERO));
      rw_d   = ld_rd;
      busW_d = ld_data;
      busy_d[ld_rd] = 1'b0;
    end
    // A new long issue applied after the clear, so set wins on a collision.
    if (iss_vld && iss_long && iss_rd != RW'(REG_ZERO)) busy_d[iss_rd] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_q   <= 1'b0;
      rw_q   <= '0;
      busW_q <= '0;
      busy_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rw_q   <= rw_d;
      busW_q <= busW_d;
      busy_q <= busy_d;
    end
  end

  assign haz   = busy_q[rs] | busy_q[rt] | busy_q[iss_rd];
  assign GPRWr = wr_q;
  assign rw    = rw_q;
  assign busW  = busW_q;
endmodule

// File: tb/tb_gpr_wb.sv
// Scenario bench for gpr_wb with a reference model feeding a per-cycle scoreboard.
module tb_gpr_wb;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        alu_vld = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_vld = 1'b0;
  logic        ld_rdy;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        iss_vld = 1'b0;
  logic        iss_long = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        haz;
  logic        GPRWr;
  logic [4:0]  rw;
  logic [31:0] busW;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] busW;
    logic [31:0] busy;
  } exp_t;

  ent_t        lq[$];
  exp_t        sb[$];
  logic [31:0] m_busy = '0;
  logic [4:0]  m_rw = '0;
  logic [31:0] m_busW = '0;

  always #5 clk = ~clk;

  gpr_wb #(.DEPTH(DEPTH), .DW(32), .RW(5)) dut (
    .clk(clk), .clr(clr),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_vld(iss_vld), .iss_long(iss_long), .iss_rd(iss_rd),
    .rs(rs), .rt(rt), .haz(haz),
    .GPRWr(GPRWr), .rw(rw), .busW(busW)
  );

  // One clock: model predicts the next write, scoreboard compares after the edge.
  task automatic tick(output bit xfer);
    exp_t        e;
    ent_t        h;
    ent_t        n;
    logic        m_rdy;
    #1;
    if (alu_vld && alu_rd != 0 && m_busy[alu_rd])
      $error("protocol violation: ALU write to busy r%0d", alu_rd);
    m_rdy = !clr && (lq.size() < DEPTH);
    tests++;
    if (ld_rdy !== m_rdy) begin
      fails++;
      $display("FAIL ld_rdy got=%b want=%b", ld_rdy, m_rdy);
    end
    xfer = ld_vld && m_rdy;
    n.rd = ld_rd;
    n.data = ld_data;
    e.wr = 1'b0;
    e.rw = m_rw;
    e.busW = m_busW;
    e.busy = m_busy;
    if (clr) begin
      lq.delete();
      e.rw = '0;
      e.busW = '0;
      e.busy = '0;
    end else begin
      if (alu_vld) begin
        e.wr = (alu_rd != 0);
        e.rw = alu_rd;
        e.busW = alu_data;
        if (xfer) lq.push_back(n);
      end else if (lq.size() > 0) begin
        h = lq.pop_front();
        e.wr = (h.rd != 0);
        e.rw = h.rd;
        e.busW = h.data;
        e.busy[h.rd] = 1'b0;
        if (xfer) lq.push_back(n);
      end else if (xfer) begin
        e.wr = (ld_rd != 0);
        e.rw = ld_rd;
        e.busW = ld_data;
        e.busy[ld_rd] = 1'b0;
      end
      if (iss_vld && iss_long && iss_rd != 0) e.busy[iss_rd] = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    m_busy = e.busy;
    m_rw = e.rw;
    m_busW = e.busW;
    tests++;
    if (GPRWr !== e.wr || rw !== e.rw || busW !== e.busW) begin
      fails++;
      $display("FAIL wb_port got wr=%b rw=%0d busW=%h want wr=%b rw=%0d busW=%h",
               GPRWr, rw, busW, e.wr, e.rw, e.busW);
    end
    tests++;
    if (haz !== (m_busy[rs] | m_busy[rt] | m_busy[iss_rd])) begin
      fails++;
      $display("FAIL haz_model got=%b want=%b", haz, m_busy[rs] | m_busy[rt] | m_busy[iss_rd]);
    end
  endtask

  task automatic test_reset();
    bit x;
    clr = 1'b1; alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5A5A5;
    ld_vld = 1'b1; ld_rd = 5'd3; ld_data = 32'h1;
    #1;
    tests++;
    if (ld_rdy !== 1'b0) begin fails++; $display("FAIL reset_ld_rdy got=%b want=0", ld_rdy); end
    tick(x);
    tick(x);
    tests++;
    if (GPRWr !== 1'b0 || rw !== 5'd0 || busW !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs got wr=%b rw=%0d busW=%h want 0/0/0", GPRWr, rw, busW);
    end
    clr = 1'b0; alu_vld = 1'b0; ld_vld = 1'b0;
    tick(x);
  endtask

  task automatic test_alu();
    bit x;
    alu_vld = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    tick(x);
    tests++;
    if (GPRWr !== 1'b1 || rw !== 5'd3 || busW !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL alu_write got wr=%b rw=%0d busW=%h want 1/3/deadbeef", GPRWr, rw, busW);
    end
    alu_vld = 1'b0;
    tick(x);
    tests++;
    if (GPRWr !== 1'b0) begin fails++; $display("FAIL alu_idle got wr=%b want 0", GPRWr); end
  endtask

  task automatic test_contention();
    bit x;
    iss_vld = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
    tick(x);
    iss_vld = 1'b0; iss_long = 1'b0; iss_rd = 5'd0; rs = 5'd7;
    #1;
    tests++;
    if (haz !== 1'b1) begin fails++; $display("FAIL haz_set got=%b want=1", haz); end
    alu_vld = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    ld_vld = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
    tick(x);
    tests++;
    if (x !== 1'b1) begin fails++; $display("FAIL contention_accept got=%b want=1", x); end
    ld_vld = 1'b0; alu_rd = 5'd2; alu_data = 32'h22;
    tick(x);
    alu_rd = 5'd4; alu_data = 32'h44;
    tick(x);
    alu_vld = 1'b0;
    tick(x);
    tests++;
    if (GPRWr !== 1'b1 || rw !== 5'd7 || busW !== 32'h1234 || haz !== 1'b0) begin
      fails++;
      $display("FAIL contention_long got wr=%b rw=%0d busW=%h haz=%b want 1/7/1234/0",
               GPRWr, rw, busW, haz);
    end
    rs = 5'd0;
    tick(x);
  endtask

  task automatic test_full();
    bit x;
    int accepted = 0;
    int nwr = 0;
    alu_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      alu_rd = 5'(20 + c); alu_data = 32'(c);
      ld_vld = (accepted < 3); ld_rd = 5'(11 + accepted); ld_data = 32'hF00 + 32'(accepted);
      tick(x);
      if (x) accepted++;
    end
    tests++;
    if (accepted != 2) begin fails++; $display("FAIL full_accepted got=%0d want=2", accepted); end
    tests++;
    if (ld_rdy !== 1'b0) begin fails++; $display("FAIL full_ld_rdy got=%b want=0", ld_rdy); end
    alu_vld = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ld_vld = (accepted < 3); ld_rd = 5'(11 + accepted); ld_data = 32'hF00 + 32'(accepted);
      tick(x);
      if (x) accepted++;
      if (GPRWr === 1'b1 && rw >= 5'd11 && rw <= 5'd13) begin
        tests++;
        if (rw !== 5'(11 + nwr) || busW !== 32'hF00 + 32'(nwr)) begin
          fails++;
          $display("FAIL full_order got rw=%0d busW=%h want rw=%0d", rw, busW, 11 + nwr);
        end
        nwr++;
      end
    end
    ld_vld = 1'b0;
    tests++;
    if (accepted != 3 || nwr != 3) begin
      fails++;
      $display("FAIL full_drain got accepted=%0d writes=%0d want 3/3", accepted, nwr);
    end
  endtask

  task automatic test_r0();
    bit x;
    alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    ld_vld = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF;
    tick(x);
    alu_rd = 5'd8; alu_data = 32'h88; ld_rd = 5'd6; ld_data = 32'h66;
    tick(x);
    alu_vld = 1'b0; ld_vld = 1'b0;
    tick(x);
    tests++;
    if (GPRWr !== 1'b0) begin fails++; $display("FAIL r0_pop got wr=%b want 0", GPRWr); end
    tick(x);
    tests++;
    if (GPRWr !== 1'b1 || rw !== 5'd6 || busW !== 32'h66) begin
      fails++;
      $display("FAIL r0_next got wr=%b rw=%0d busW=%h want 1/6/66", GPRWr, rw, busW);
    end
    ld_vld = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF;
    tick(x);
    ld_vld = 1'b0;
    tests++;
    if (GPRWr !== 1'b0) begin fails++; $display("FAIL r0_bypass got wr=%b want 0", GPRWr); end
    alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    tick(x);
    alu_vld = 1'b0;
    tests++;
    if (GPRWr !== 1'b0) begin fails++; $display("FAIL r0_alu got wr=%b want 0", GPRWr); end
    iss_vld = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
    tick(x);
    iss_vld = 1'b0; iss_long = 1'b0; rs = 5'd0; rt = 5'd0;
    #1;
    tests++;
    if (haz !== 1'b0) begin fails++; $display("FAIL r0_busy got haz=%b want 0", haz); end
  endtask

  task automatic test_set_wins();
    bit x;
    iss_vld = 1'b1; iss_long = 1'b1; iss_rd = 5'd9;
    tick(x);
    iss_vld = 1'b0;
    ld_vld = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    iss_vld = 1'b1; iss_rd = 5'd9;
    tick(x);
    ld_vld = 1'b0; iss_vld = 1'b0; iss_long = 1'b0; iss_rd = 5'd0; rs = 5'd9;
    #1;
    tests++;
    if (GPRWr !== 1'b1 || rw !== 5'd9 || busW !== 32'h99 || haz !== 1'b1) begin
      fails++;
      $display("FAIL set_wins got wr=%b rw=%0d busW=%h haz=%b want 1/9/99/1",
               GPRWr, rw, busW, haz);
    end
    alu_vld = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_vld = 1'b1; ld_rd = 5'd9; ld_data = 32'hAA;
    tick(x);
    ld_data = 32'hBB;
    tick(x);
    clr = 1'b1; alu_vld = 1'b0; ld_vld = 1'b0;
    tick(x);
    tests++;
    if (GPRWr !== 1'b0 || rw !== 5'd0 || busW !== 32'd0 || haz !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got wr=%b rw=%0d busW=%h haz=%b want 0/0/0/0", GPRWr, rw, busW, haz);
    end
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(x);
      tests++;
      if (GPRWr !== 1'b0) begin fails++; $display("FAIL mid_reset_flush got wr=%b want 0", GPRWr); end
    end
    rs = 5'd0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_contention();
    test_full();
    test_r0();
    test_set_wins();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
